// File: rtl/pkg_rv32i.sv
// Shared RV32I definitions for the write-back path: widths, requester IDs
// and the write request carried into the register-file output stage.
package pkg_rv32i;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/marcador_ocupacion.sv
// Register scoreboard: one busy bit per architectural register, set at issue
// and cleared on register-file commit, with two combinational hazard queries.
module marcador_ocupacion #(
    parameter int AW = pkg_rv32i::AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_q_addr1,
    input  logic [AW-1:0] i_q_addr2,
    output logic          o_busy1,
    output logic          o_busy2
);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    // Clear is applied first so a same-edge reservation of that register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_en) begin
            w_busy_next[i_clr_addr] = 1'b0;
        end
        if (i_set_en && (i_set_addr != '0)) begin
            w_busy_next[i_set_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy1 = r_busy[i_q_addr1];
    assign o_busy2 = r_busy[i_q_addr2];

endmodule

// File: rtl/arbitro_escritura_reg.sv
// Write-back arbiter for the 32x32 register file: shares one write port
// between ALU and load unit, with anti-starvation and a RAW scoreboard.
module arbitro_escritura_reg #(
    parameter int XLEN       = pkg_rv32i::XLEN,
    parameter int AW         = pkg_rv32i::AW,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            res_valid,
    input  logic [AW-1:0]   res_addr,
    input  logic [AW-1:0]   q_addr1,
    input  logic [AW-1:0]   q_addr2,
    output logic            q_busy1,
    output logic            q_busy2,
    output logic            we,
    output logic [AW-1:0]   write_addr,
    output logic [XLEN-1:0] write_data
);
    import pkg_rv32i::*;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    // Handshake: a request transfers on an edge where valid && ready. Ready is
    // derived from both valids; requesters must not look at ready before
    // raising valid and must hold addr/data steady until accepted.
    logic       w_grant_alu;
    logic       w_grant_mem;
    logic       w_accept;
    logic [AW-1:0]   w_sel_addr;
    logic [XLEN-1:0] w_sel_data;
    logic [2:0]      r_starve;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_data;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (alu_valid && mem_valid) begin
            if (r_starve == STARVE_LIM) begin
                w_grant_alu = 1'b1;
            end else begin
                w_grant_mem = 1'b1;
            end
        end else if (alu_valid) begin
            w_grant_alu = 1'b1;
        end else if (mem_valid) begin
            w_grant_mem = 1'b1;
        end
    end

    assign alu_ready  = w_grant_alu & rst;
    assign mem_ready  = w_grant_mem & rst;
    assign w_accept   = alu_ready | mem_ready;
    assign w_sel_addr = alu_ready ? alu_addr : mem_addr;
    assign w_sel_data = alu_ready ? alu_data : mem_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (!alu_valid || alu_ready) begin
            r_starve <= '0;
        end else if (r_starve < STARVE_LIM) begin
            r_starve <= r_starve + 3'd1;
        end
    end

    // Writes to r0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_we   <= (w_sel_addr != '0);
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign we         = r_we;
    assign write_addr = r_addr;
    assign write_data = r_data;

    marcador_ocupacion #(
        .AW(AW)
    ) u_marcador (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_set_en   (res_valid),
        .i_set_addr (res_addr),
        .i_clr_en   (r_we),
        .i_clr_addr (r_addr),
        .i_q_addr1  (q_addr1),
        .i_q_addr2  (q_addr2),
        .o_busy1    (q_busy1),
        .o_busy2    (q_busy2)
    );

endmodule

// File: tb/tb_arbitro_escritura_reg.sv
// Directed bench for arbitro_escritura_reg with a small register-file stand-in
// that commits whatever the DUT drives on its write port.
module tb_arbitro_escritura_reg;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        res_valid;
    logic [4:0]  res_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rf [32];
    logic [7:0]  exp_alu_pat;

    arbitro_escritura_reg #(
        .XLEN(32),
        .AW(5),
        .STARVE_MAX(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .q_addr1    (q_addr1),
        .q_addr2    (q_addr2),
        .q_busy1    (q_busy1),
        .q_busy2    (q_busy2),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file stand-in: r0 is hardwired to zero.
    always @(posedge clk) begin
        if (we && write_addr != 5'd0) begin
            rf[write_addr] <= write_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst       = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd9;
        alu_data  = 32'h11111111;
        mem_valid = 1'b0;
        mem_addr  = 5'd0;
        mem_data  = 32'h0;
        res_valid = 1'b0;
        res_addr  = 5'd0;
        q_addr1   = 5'd0;
        q_addr2   = 5'd0;

        // Reset state, with a request pending that must not be acknowledged.
        tick();
        tick();
        check("rst_we", we, 1'b0);
        check("rst_waddr", write_addr, 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_busy", q_busy1, 1'b0);
        alu_valid = 1'b0;
        rst       = 1'b1;
        tick();
        check("post_rst_we", we, 1'b0);

        // Single ALU requester.
        alu_valid = 1'b1;
        alu_addr  = 5'd1;
        alu_data  = 32'hDEADBEEF;
        #1;
        check("single_alu_ready", alu_ready, 1'b1);
        check("single_mem_ready", mem_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("single_we", we, 1'b1);
        check("single_waddr", write_addr, 32'd1);
        check("single_wdata", write_data, 32'hDEADBEEF);
        tick();
        check("single_we_drop", we, 1'b0);
        check("single_rf1", rf[1], 32'hDEADBEEF);

        // Write to r0 is acknowledged but never enables the write port.
        mem_valid = 1'b1;
        mem_addr  = 5'd0;
        mem_data  = 32'h12345678;
        #1;
        check("r0_mem_ready", mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        #1;
        check("r0_we", we, 1'b0);
        tick();
        check("r0_we_after", we, 1'b0);
        check("r0_rf0", rf[0], 32'h0);

        // Contention: mem wins three times, then the starved ALU.
        exp_alu_pat = 8'b1000_1000;
        alu_valid = 1'b1;
        alu_addr  = 5'd3;
        alu_data  = 32'hAAAA0003;
        mem_valid = 1'b1;
        mem_addr  = 5'd4;
        mem_data  = 32'hBBBB0004;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("grant_alu_%0d", i), alu_ready, exp_alu_pat[i]);
            check($sformatf("grant_mem_%0d", i), mem_ready, !exp_alu_pat[i]);
            tick();
            check($sformatf("b2b_we_%0d", i), we, 1'b1);
            check($sformatf("b2b_waddr_%0d", i), write_addr, exp_alu_pat[i] ? 32'd3 : 32'd4);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        check("contend_rf3", rf[3], 32'hAAAA0003);
        check("contend_rf4", rf[4], 32'hBBBB0004);

        // Scoreboard reserve, then clear on commit with no bypass.
        res_valid = 1'b1;
        res_addr  = 5'd2;
        q_addr1   = 5'd2;
        #1;
        check("sb_before_set", q_busy1, 1'b0);
        tick();
        res_valid = 1'b0;
        #1;
        check("sb_set", q_busy1, 1'b1);
        alu_valid = 1'b1;
        alu_addr  = 5'd2;
        alu_data  = 32'hCAFEBABE;
        tick();
        alu_valid = 1'b0;
        #1;
        check("sb_we", we, 1'b1);
        check("sb_busy_until_commit", q_busy1, 1'b1);
        tick();
        check("sb_cleared", q_busy1, 1'b0);
        check("sb_rf2", rf[2], 32'hCAFEBABE);

        // Reserving r0 never marks it busy.
        res_valid = 1'b1;
        res_addr  = 5'd0;
        q_addr1   = 5'd0;
        tick();
        res_valid = 1'b0;
        #1;
        check("sb_r0", q_busy1, 1'b0);

        // Same-edge set and clear of r7: the set survives.
        q_addr2   = 5'd7;
        res_valid = 1'b1;
        res_addr  = 5'd7;
        tick();
        res_valid = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd7;
        alu_data  = 32'h00000777;
        tick();
        alu_valid = 1'b0;
        res_valid = 1'b1;
        res_addr  = 5'd7;
        #1;
        check("coll_we", we, 1'b1);
        check("coll_waddr", write_addr, 32'd7);
        tick();
        res_valid = 1'b0;
        #1;
        check("coll_busy7", q_busy2, 1'b1);
        tick();
        check("coll_busy7_hold", q_busy2, 1'b1);

        // Asynchronous reset in the middle of a write to r5.
        q_addr1   = 5'd5;
        res_valid = 1'b1;
        res_addr  = 5'd5;
        tick();
        res_valid = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd5;
        alu_data  = 32'h55555555;
        tick();
        alu_valid = 1'b0;
        #1;
        check("midrst_we_pre", we, 1'b1);
        check("midrst_busy_pre", q_busy1, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_we", we, 1'b0);
        check("midrst_waddr", write_addr, 32'd0);
        check("midrst_busy5", q_busy1, 1'b0);
        check("midrst_busy7", q_busy2, 1'b0);
        alu_valid = 1'b1;
        alu_addr  = 5'd9;
        #1;
        check("midrst_alu_ready", alu_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        rst       = 1'b1;
        tick();
        check("midrst_no_stale_we", we, 1'b0);
        tick();
        check("midrst_no_stale_we2", we, 1'b0);
        check("midrst_rf5", rf[5], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
